load_merge_unit: RTL and testbench

- Sits directly downstream of the post-commit store buffer and the D-cache on the load path.
- Holds one outstanding load at a time.
- Captures the store buffer's registered forward result (hit/wmask/data) one cycle after the load is presented, then waits for the D-cache response if needed.
- Merges bytes (forwarded bytes win), aligns and sign/zero-extends per funct3, and presents the result to writeback with a valid/ready handshake.

---
 rtl/load_merge_unit_if.sv | 37 +++
 rtl/load_merge_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_merge_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_merge_unit_if.sv
// rtl/load_merge_unit_if.sv - load request, store-forward, D-cache and writeback bundle
// master: load issue / store buffer / D-cache / writeback side (drives requests, responses, wb_ready)
// slave : load_merge_unit (drives load_req_ready and the wb_* result)
interface load_merge_unit_if #(
    parameter int ROB_IDX_WIDTH  = 5,
    parameter int PHYS_REG_WIDTH = 6
);
    logic                      flush;
    logic                      load_req_valid;
    logic                      load_req_ready;
    logic [31:0]               load_addr;
    logic [2:0]                load_funct3;
    logic [ROB_IDX_WIDTH-1:0]  load_rob_idx;
    logic [PHYS_REG_WIDTH-1:0] load_pd;
    logic                      fwd_hit;
    logic [3:0]                fwd_wmask;
    logic [31:0]               fwd_data;
    logic                      dcache_resp;
    logic [31:0]               dcache_rdata;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [31:0]               wb_data;
    logic [ROB_IDX_WIDTH-1:0]  wb_rob_idx;
    logic [PHYS_REG_WIDTH-1:0] wb_pd;

    modport master (
        output flush, load_req_valid, load_addr, load_funct3, load_rob_idx, load_pd,
        output fwd_hit, fwd_wmask, fwd_data, dcache_resp, dcache_rdata, wb_ready,
        input  load_req_ready, wb_valid, wb_data, wb_rob_idx, wb_pd
    );

    modport slave (
        input  flush, load_req_valid, load_addr, load_funct3, load_rob_idx, load_pd,
        input  fwd_hit, fwd_wmask, fwd_data, dcache_resp, dcache_rdata, wb_ready,
        output load_req_ready, wb_valid, wb_data, wb_rob_idx, wb_pd
    );
endinterface

// File: rtl/load_merge_unit.sv
// rtl/load_merge_unit.sv - merges store-buffer forwarding with D-cache data for one outstanding load
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of load_merge_unit_if (load request, forward result, D-cache response, writeback)
module load_merge_unit #(
    parameter int ROB_IDX_WIDTH  = 5,
    parameter int PHYS_REG_WIDTH = 6
) (
    input logic            clk,
    input logic            rst,
    load_merge_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FWD     = 3'd1,
        WAIT_DC = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic                      discard_q;
    logic [1:0]                off_q;
    logic [2:0]                funct3_q;
    logic [3:0]                rmask_q;
    logic [ROB_IDX_WIDTH-1:0]  rob_q;
    logic [PHYS_REG_WIDTH-1:0] pd_q;
    logic                      fwd_hit_q;
    logic [3:0]                fwd_wmask_q;
    logic [31:0]               fwd_data_q;
    logic [31:0]               dc_data_q;
    logic [31:0]               wb_data_q;
    logic [ROB_IDX_WIDTH-1:0]  wb_rob_q;
    logic [PHYS_REG_WIDTH-1:0] wb_pd_q;

    logic        accept;
    logic        dc_live;
    logic        eff_hit;
    logic [3:0]  eff_wmask;
    logic [31:0] eff_fwd_data;
    logic [31:0] eff_dc_data;
    logic [31:0] merged;
    logic [31:0] shifted;
    logic [31:0] result;
    logic        full_cover;
    logic        take_result;
    logic        set_discard;

    function automatic logic [3:0] rmask_of(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0, 3'd4: return 4'b0001 << off;
            3'd1, 3'd5: return 4'b0011 << off;
            default:    return 4'b1111;
        endcase
    endfunction

    assign bus.load_req_ready = (state_q == IDLE) && !discard_q && !bus.flush;
    assign accept             = bus.load_req_valid && bus.load_req_ready;

    // A response arriving while discard_q is set belongs to an already
    // completed full-cover load and must not touch the current one.
    assign dc_live = bus.dcache_resp && !discard_q;

    // In FWD the forward result is only on the inputs this cycle; later
    // states use the captured copy. Same for a D-cache word arriving now.
    assign eff_hit      = (state_q == FWD) ? bus.fwd_hit   : fwd_hit_q;
    assign eff_wmask    = (state_q == FWD) ? bus.fwd_wmask : fwd_wmask_q;
    assign eff_fwd_data = (state_q == FWD) ? bus.fwd_data  : fwd_data_q;
    assign eff_dc_data  = dc_live ? bus.dcache_rdata : dc_data_q;

    assign full_cover = eff_hit && ((eff_wmask & rmask_q) == rmask_q);

    always_comb begin
        merged = eff_dc_data;
        for (int i = 0; i < 4; i++) begin
            if (eff_hit && eff_wmask[i]) begin
                merged[8*i +: 8] = eff_fwd_data[8*i +: 8];
            end
        end
    end

    assign shifted = merged >> {off_q, 3'b000};

    always_comb begin
        result = shifted;
        case (funct3_q)
            3'd0:    result = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    result = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    result = {24'b0, shifted[7:0]};
            3'd5:    result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        take_result = 1'b0;
        set_discard = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = FWD;
            end
            FWD: begin
                if (bus.flush) begin
                    state_d = dc_live ? IDLE : DRAIN;
                end else if (full_cover) begin
                    state_d     = DONE;
                    take_result = 1'b1;
                    set_discard = !dc_live;
                end else if (dc_live) begin
                    state_d     = DONE;
                    take_result = 1'b1;
                end else begin
                    state_d = WAIT_DC;
                end
            end
            WAIT_DC: begin
                if (bus.flush) begin
                    state_d = dc_live ? IDLE : DRAIN;
                end else if (dc_live) begin
                    state_d     = DONE;
                    take_result = 1'b1;
                end
            end
            DRAIN: begin
                if (dc_live) state_d = IDLE;
            end
            DONE: begin
                if (bus.flush || bus.wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            discard_q   <= 1'b0;
            off_q       <= '0;
            funct3_q    <= '0;
            rmask_q     <= '0;
            rob_q       <= '0;
            pd_q        <= '0;
            fwd_hit_q   <= 1'b0;
            fwd_wmask_q <= '0;
            fwd_data_q  <= '0;
            dc_data_q   <= '0;
            wb_data_q   <= '0;
            wb_rob_q    <= '0;
            wb_pd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                off_q    <= bus.load_addr[1:0];
                funct3_q <= bus.load_funct3;
                rmask_q  <= rmask_of(bus.load_funct3, bus.load_addr[1:0]);
                rob_q    <= bus.load_rob_idx;
                pd_q     <= bus.load_pd;
            end
            if (state_q == FWD) begin
                fwd_hit_q   <= bus.fwd_hit;
                fwd_wmask_q <= bus.fwd_wmask;
                fwd_data_q  <= bus.fwd_data;
            end
            if (dc_live && (state_q == FWD || state_q == WAIT_DC)) begin
                dc_data_q <= bus.dcache_rdata;
            end
            if (take_result) begin
                wb_data_q <= result;
                wb_rob_q  <= rob_q;
                wb_pd_q   <= pd_q;
            end
            if (set_discard) begin
                discard_q <= 1'b1;
            end else if (discard_q && bus.dcache_resp) begin
                discard_q <= 1'b0;
            end
        end
    end

    assign bus.wb_valid   = (state_q == DONE);
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_rob_idx = wb_rob_q;
    assign bus.wb_pd      = wb_pd_q;

endmodule

// File: tb/tb_load_merge_unit.sv
// tb/tb_load_merge_unit.sv - directed and randomized bench for load_merge_unit
module tb_load_merge_unit;

    localparam int RW = 5;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_merge_unit_if #(.ROB_IDX_WIDTH(RW), .PHYS_REG_WIDTH(PW)) bus ();

    load_merge_unit #(.ROB_IDX_WIDTH(RW), .PHYS_REG_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: assemble the four bytes, pick the ones the access needs,
    // then extend with plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [31:0] addr, input logic [2:0] f3,
                                               input logic hit, input logic [3:0] wmask,
                                               input logic [31:0] fdata, input logic [31:0] rdata);
        int b[4];
        int off;
        longint v;
        off = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            b[i] = (hit && wmask[i]) ? int'(fdata[8*i +: 8]) : int'(rdata[8*i +: 8]);
        end
        case (f3)
            3'd0: begin v = b[off]; if (v > 127) v = v - 256; end
            3'd4: v = b[off];
            3'd1: begin v = b[off] + 256 * b[off+1]; if (v > 32767) v = v - 65536; end
            3'd5: v = b[off] + 256 * b[off+1];
            default: v = b[0] + 256 * b[1] + 65536 * b[2] + 64'd16777216 * b[3];
        endcase
        return v[31:0];
    endfunction

    function automatic bit covers(input logic [31:0] addr, input logic [2:0] f3,
                                  input logic hit, input logic [3:0] wmask);
        int n;
        int off;
        off = int'(addr[1:0]);
        n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        if (!hit) return 1'b0;
        for (int j = 0; j < n; j++) begin
            if (!wmask[off+j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic idle_inputs();
        bus.flush          = 1'b0;
        bus.load_req_valid = 1'b0;
        bus.load_addr      = '0;
        bus.load_funct3    = '0;
        bus.load_rob_idx   = '0;
        bus.load_pd        = '0;
        bus.fwd_hit        = 1'b0;
        bus.fwd_wmask      = '0;
        bus.fwd_data       = '0;
        bus.dcache_resp    = 1'b0;
        bus.dcache_rdata   = '0;
        bus.wb_ready       = 1'b0;
    endtask

    task automatic present(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [RW-1:0] rob, input logic [PW-1:0] pd);
        bus.load_req_valid = 1'b1;
        bus.load_addr      = addr;
        bus.load_funct3    = f3;
        bus.load_rob_idx   = rob;
        bus.load_pd        = pd;
    endtask

    // Called at a negedge with the unit idle. Negedge k lies in cycle T+k.
    task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [RW-1:0] rob, input logic [PW-1:0] pd,
                           input logic hit, input logic [3:0] wmask, input logic [31:0] fdata,
                           input logic [31:0] rdata, input int dc_lat, input int stall,
                           input logic [31:0] exp);
        bit full;
        int rise;
        int k_end;
        bit vexp;
        bit pending;
        full  = covers(addr, f3, hit, wmask);
        rise  = full ? 2 : dc_lat + 1;
        k_end = (rise + stall + 1 > dc_lat + 1) ? rise + stall + 1 : dc_lat + 1;
        present(addr, f3, rob, pd);
        #1 check({name, ":req_ready"}, 32'(bus.load_req_ready), 32'd1);
        for (int k = 1; k <= k_end; k++) begin
            @(negedge clk);
            bus.load_req_valid = 1'b0;
            bus.load_addr      = $urandom();
            bus.fwd_hit        = (k == 1) ? hit   : 1'($urandom_range(0, 1));
            bus.fwd_wmask      = (k == 1) ? wmask : 4'($urandom());
            bus.fwd_data       = (k == 1) ? fdata : $urandom();
            bus.dcache_resp    = (k == dc_lat);
            bus.dcache_rdata   = (k == dc_lat) ? rdata : $urandom();
            bus.wb_ready       = (k < rise) ? 1'($urandom_range(0, 1)) : (k == rise + stall);
            #1;
            vexp    = (k >= rise) && (k <= rise + stall);
            pending = full && (dc_lat >= 2) && (k <= dc_lat);
            check({name, ":wb_valid"}, 32'(bus.wb_valid), 32'(vexp));
            if (vexp) begin
                check({name, ":wb_data"}, bus.wb_data, exp);
                check({name, ":wb_rob_idx"}, 32'(bus.wb_rob_idx), 32'(rob));
                check({name, ":wb_pd"}, 32'(bus.wb_pd), 32'(pd));
            end
            check({name, ":ready"}, 32'(bus.load_req_ready),
                  32'((k >= rise + stall + 1) && !pending));
        end
        bus.wb_ready = 1'b0;
    endtask

    // Flush asserted in cycle T+flush_k; wb_ready held low throughout.
    task automatic flush_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [RW-1:0] rob, input logic [PW-1:0] pd,
                              input logic hit, input logic [3:0] wmask, input logic [31:0] fdata,
                              input logic [31:0] rdata, input int dc_lat, input int flush_k);
        bit full;
        int rise;
        int ready_k;
        bit vexp;
        logic [31:0] exp;
        full    = covers(addr, f3, hit, wmask);
        rise    = full ? 2 : dc_lat + 1;
        ready_k = ((flush_k > dc_lat) ? flush_k : dc_lat) + 1;
        exp     = ref_result(addr, f3, hit, wmask, fdata, rdata);
        present(addr, f3, rob, pd);
        #1 check({name, ":req_ready"}, 32'(bus.load_req_ready), 32'd1);
        for (int k = 1; k <= ready_k; k++) begin
            @(negedge clk);
            bus.load_req_valid = 1'b0;
            bus.fwd_hit        = (k == 1) ? hit   : 1'($urandom_range(0, 1));
            bus.fwd_wmask      = (k == 1) ? wmask : 4'($urandom());
            bus.fwd_data       = (k == 1) ? fdata : $urandom();
            bus.dcache_resp    = (k == dc_lat);
            bus.dcache_rdata   = (k == dc_lat) ? rdata : $urandom();
            bus.flush          = (k == flush_k);
            bus.wb_ready       = 1'b0;
            #1;
            vexp = (k >= rise) && (k <= flush_k);
            check({name, ":wb_valid"}, 32'(bus.wb_valid), 32'(vexp));
            if (vexp) check({name, ":wb_data"}, bus.wb_data, exp);
            check({name, ":ready"}, 32'(bus.load_req_ready), 32'(k >= ready_k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr, fdata, rdata, rnd;
        logic [2:0]  f3;
        logic [3:0]  wmask;
        logic        hit;
        int          sel;

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst:wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst:wb_data", bus.wb_data, 32'd0);
        check("rst:wb_rob_idx", 32'(bus.wb_rob_idx), 32'd0);
        check("rst:wb_pd", 32'(bus.wb_pd), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst:ready_after", 32'(bus.load_req_ready), 32'd1);

        do_load("lw_plain", 32'h100, 3'd2, 5'd3, 6'd9, 1'b0, 4'h0, 32'h0,
                32'hDEADBEEF, 3, 2, 32'hDEADBEEF);
        do_load("lb_sext", 32'h103, 3'd0, 5'd4, 6'd10, 1'b0, 4'h0, 32'h0,
                32'h80FF_0000, 2, 0, 32'hFFFF_FF80);
        do_load("lbu_zext", 32'h103, 3'd4, 5'd5, 6'd11, 1'b0, 4'h0, 32'h0,
                32'h80FF_0000, 1, 1, 32'h0000_0080);
        do_load("lh_full", 32'h202, 3'd1, 5'd6, 6'd12, 1'b1, 4'b1100, 32'h8001_0000,
                32'h1234_5678, 4, 0, 32'hFFFF_8001);
        do_load("lw_partial", 32'h300, 3'd2, 5'd7, 6'd13, 1'b1, 4'b0101, 32'h00AA_00BB,
                32'h1122_3344, 2, 0, 32'h11AA_33BB);
        do_load("bp_first", 32'h404, 3'd2, 5'd8, 6'd14, 1'b0, 4'h0, 32'h0,
                32'hCAFE_F00D, 2, 3, 32'hCAFE_F00D);
        do_load("bp_b2b", 32'h406, 3'd5, 5'd9, 6'd15, 1'b0, 4'h0, 32'h0,
                32'h9876_0000, 1, 0, 32'h0000_9876);
        flush_load("flush_wait", 32'h500, 3'd2, 5'd10, 6'd16, 1'b0, 4'h0, 32'h0,
                   32'hBAD0_BAD0, 4, 2);
        do_load("after_drain", 32'h504, 3'd2, 5'd11, 6'd17, 1'b0, 4'h0, 32'h0,
                32'h0BAD_CAFE, 3, 0, 32'h0BAD_CAFE);

        // Flush in IDLE must block a simultaneous request.
        present(32'h600, 3'd2, 5'd12, 6'd18);
        bus.flush = 1'b1;
        #1 check("idle_flush:ready", 32'(bus.load_req_ready), 32'd0);
        @(negedge clk);
        bus.flush          = 1'b0;
        bus.load_req_valid = 1'b0;
        #1 check("idle_flush:no_accept", 32'(bus.load_req_ready), 32'd1);

        // Reset while a full-cover result waits with its response still owed.
        present(32'h700, 3'd2, 5'd13, 6'd19);
        @(negedge clk);
        bus.load_req_valid = 1'b0;
        bus.fwd_hit        = 1'b1;
        bus.fwd_wmask      = 4'hF;
        bus.fwd_data       = 32'h5555_AAAA;
        @(negedge clk);
        bus.fwd_hit = 1'b0;
        #1 check("midrst:valid_before", 32'(bus.wb_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst:wb_valid", 32'(bus.wb_valid), 32'd0);
        check("midrst:wb_data", bus.wb_data, 32'd0);
        check("midrst:ready", 32'(bus.load_req_ready), 32'd1);
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 4);
            f3  = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd1 : (sel == 2) ? 3'd2 :
                  (sel == 3) ? 3'd4 : 3'd5;
            rnd  = $urandom();
            addr = {rnd[31:2], 2'b00};
            if (f3 == 3'd0 || f3 == 3'd4) addr[1:0] = rnd[1:0];
            else if (f3 == 3'd1 || f3 == 3'd5) addr[1] = rnd[1];
            hit   = 1'($urandom_range(0, 1));
            wmask = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom());
            fdata = $urandom();
            rdata = $urandom();
            if ($urandom_range(0, 4) == 0) begin
                flush_load("rnd_flush", addr, f3, 5'($urandom()), 6'($urandom()), hit, wmask,
                           fdata, rdata, $urandom_range(1, 4), $urandom_range(1, 5));
            end else begin
                do_load("rnd", addr, f3, 5'($urandom()), 6'($urandom()), hit, wmask, fdata,
                        rdata, $urandom_range(1, 4), $urandom_range(0, 3),
                        ref_result(addr, f3, hit, wmask, fdata, rdata));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
